// File: rtl/uart_tx_buf.sv
// uart_tx_buf: byte FIFO feeding an 8N1 UART transmitter with sticky overflow flag
module uart_tx_buf #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 9600,
   parameter int DEPTH    = 16
) (
   input  logic                     sclk,
   input  logic                     rst_n,
   input  logic                     tx_flag,
   input  logic [7:0]               tx_data,
   input  logic                     clr_ovf,
   output logic                     tx,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_cnt,
   output logic                     overflow
);
   localparam int BIT_CYC = CLK_FREQ / BAUD;
   localparam int CW = $clog2(BIT_CYC + 1);
   localparam int AW = $clog2(DEPTH);
   localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
   logic [1:0]    state;
   logic [CW-1:0] bit_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic          bit_end, pop, push;
   always_comb begin
      bit_end = bit_cnt == CW'(BIT_CYC - 1);
      pop     = fifo_cnt != '0 && (state == IDLE || (state == STOP && bit_end));
      push    = tx_flag && (fifo_cnt != (AW+1)'(DEPTH) || pop);
      busy    = state != IDLE || fifo_cnt != '0;
   end
   always_ff @(posedge sclk)
      if (push) mem[wp] <= tx_data;
   always_ff @(posedge sclk or negedge rst_n)
      if (!rst_n) begin
         wp       <= '0;
         rp       <= '0;
         fifo_cnt <= '0;
         overflow <= 1'b0;
         state    <= IDLE;
         bit_cnt  <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         tx       <= 1'b1;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         fifo_cnt <= fifo_cnt + (AW+1)'(push) - (AW+1)'(pop);
         overflow <= (tx_flag && !push) || (overflow && !clr_ovf);
         bit_cnt  <= (state == IDLE || bit_end) ? '0 : bit_cnt + 1'b1;
         // a pop starts a frame from IDLE or straight out of a finished stop bit
         if (pop) begin
            shreg   <= mem[rp];
            state   <= START;
            bit_idx <= '0;
            tx      <= 1'b0;
         end else if (bit_end) begin
            if (state == START) begin
               state <= DATA;
               tx    <= shreg[0];
            end else if (state == DATA) begin
               shreg   <= shreg >> 1;
               bit_idx <= bit_idx + 1'b1;
               tx      <= bit_idx == 3'd7 ? 1'b1 : shreg[1];
               state   <= bit_idx == 3'd7 ? STOP : DATA;
            end else if (state == STOP) begin
               state <= IDLE;
            end
         end
      end
endmodule
